// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared playfield constants, types and mask helper
package tetris_pkg;

    localparam int COLS = 10;
    localparam int ROWS = 24;
    localparam int CELL = 20;

    typedef logic [15:0]     piece_mask_t;
    typedef logic [COLS-1:0] grid_row_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        SCAN  = 2'd2,
        SHIFT = 2'd3
    } board_state_e;

    // Bit position of piece cell (r,c) inside a 4x4 mask, r=0 top, c=0 left.
    function automatic logic [3:0] mask_bit(input int r, input int c);
        return 4'(4 * r + c);
    endfunction

endpackage

// File: rtl/piece_cell_map.sv
// rtl/piece_cell_map.sv - map a 4x4 piece mask at an anchor onto grid cells
module piece_cell_map
    import tetris_pkg::*;
(
    input  logic [15:0]            mask,
    input  logic [4:0]             col,
    input  logic [4:0]             row,
    output logic [ROWS*COLS-1:0]   cells,
    output logic                   oob
);

    logic [5:0] tr;
    logic [5:0] tc;
    logic [7:0] idx;

    // Each set mask bit lands on one grid cell, or flags out-of-bounds; sums
    // are 6 bits wide so large anchors never wrap back into the grid.
    always_comb begin
        cells = '0;
        oob   = 1'b0;
        tr    = '0;
        tc    = '0;
        idx   = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                tr  = {1'b0, row} + 6'(r);
                tc  = {1'b0, col} + 6'(c);
                idx = 8'(tr) * 8'(COLS) + 8'(tc);
                if (mask[mask_bit(r, c)]) begin
                    if (tr < 6'(ROWS) && tc < 6'(COLS)) begin
                        cells[idx] = 1'b1;
                    end else begin
                        oob = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/board_grid.sv
// rtl/board_grid.sv - playfield store: piece lock, row clear, collision and pixel lookup
module board_grid
    import tetris_pkg::*;
#(
    parameter int ORIGIN_X = 220,
    parameter int ORIGIN_Y = 0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        lock_valid,
    output logic        lock_ready,
    input  logic [15:0] lock_mask,
    input  logic [4:0]  lock_col,
    input  logic [4:0]  lock_row,
    input  logic [15:0] query_mask,
    input  logic [4:0]  query_col,
    input  logic [4:0]  query_row,
    output logic        query_hit,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic        drawGrid,
    output logic [15:0] lines_cleared,
    output logic        overflow
);

    board_state_e          state;
    board_state_e          state_next;
    grid_row_t [ROWS-1:0]  grid;
    logic [ROWS*COLS-1:0]  grid_flat;
    piece_mask_t           lk_mask;
    logic [4:0]            lk_col;
    logic [4:0]            lk_row;
    logic [4:0]            scan_row;
    logic                  row_full;

    logic [ROWS*COLS-1:0]  lock_cells;
    logic                  lock_oob;
    logic [ROWS*COLS-1:0]  query_cells;
    logic                  query_oob;

    logic [10:0]           dx;
    logic [10:0]           dy;
    logic                  in_window;
    logic [3:0]            px_col;
    logic [4:0]            px_row;
    logic                  pixel_on;

    assign grid_flat = grid;
    assign row_full  = &grid[scan_row];

    piece_cell_map u_lock_map (
        .mask  (lk_mask),
        .col   (lk_col),
        .row   (lk_row),
        .cells (lock_cells),
        .oob   (lock_oob)
    );

    piece_cell_map u_query_map (
        .mask  (query_mask),
        .col   (query_col),
        .row   (query_row),
        .cells (query_cells),
        .oob   (query_oob)
    );

    // State register.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: one write cycle, then scan bottom-up; a full row detours
    // through SHIFT and comes back to re-check the same row.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (lock_valid) state_next = WRITE;
            WRITE: state_next = SCAN;
            SCAN: begin
                if (row_full) begin
                    state_next = SHIFT;
                end else if (scan_row == 5'd0) begin
                    state_next = IDLE;
                end
            end
            SHIFT: state_next = SCAN;
            default: state_next = IDLE;
        endcase
    end

    // Handshake output: only idle accepts a new lock.
    always_comb begin
        lock_ready = (state == IDLE);
    end

    // Grid datapath: latch lock, merge piece, walk scan row, collapse full rows.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            grid          <= '0;
            lk_mask       <= '0;
            lk_col        <= '0;
            lk_row        <= '0;
            scan_row      <= '0;
            lines_cleared <= '0;
            overflow      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (lock_valid) begin
                        lk_mask <= lock_mask;
                        lk_col  <= lock_col;
                        lk_row  <= lock_row;
                    end
                end
                WRITE: begin
                    grid     <= grid | lock_cells;
                    overflow <= overflow | lock_oob;
                    scan_row <= 5'(ROWS - 1);
                end
                SCAN: begin
                    if (!row_full && scan_row != 5'd0) begin
                        scan_row <= scan_row - 5'd1;
                    end
                end
                SHIFT: begin
                    for (int i = 1; i < ROWS; i++) begin
                        if (5'(i) <= scan_row) begin
                            grid[i] <= grid[i-1];
                        end
                    end
                    grid[0]       <= '0;
                    lines_cleared <= lines_cleared + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Collision query, registered every cycle against the live grid.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            query_hit <= 1'b0;
        end else begin
            query_hit <= (|(query_cells & grid_flat)) | query_oob;
        end
    end

    // Pixel to cell: subtract origin (borrow bit marks left/above window),
    // bound the far edge, then divide by the cell size.
    always_comb begin
        dx        = {1'b0, DrawX} - 11'(ORIGIN_X);
        dy        = {1'b0, DrawY} - 11'(ORIGIN_Y);
        in_window = !dx[10] && (dx < 11'(COLS * CELL)) &&
                    !dy[10] && (dy < 11'(ROWS * CELL));
        px_col    = 4'(dx[9:0] / 10'(CELL));
        px_row    = 5'(dy[9:0] / 10'(CELL));
        pixel_on  = in_window && grid[px_row][px_col];
    end

    // Registered pixel hit for the colour mapper.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            drawGrid <= 1'b0;
        end else begin
            drawGrid <= pixel_on;
        end
    end

endmodule
